step_counter_arbiter: RTL
=========================

// Module: step_counter_arbiter
// PURPOSE
//  Shares one modulo-2^CW step counter between NREQ requesters.
//  A round-robin arbiter grants the counter to one requester at a time. Only
//  the owner's step pulses advance the count.
//  Sits between the requesting control blocks and the shared count/phase
//  consumer. Replaces ad-hoc ORing of din strobes into the counter.
// PARAMETERS
//  NREQ      4   number of requesters (2..16)
//  CW        2   counter width; count wraps modulo 2^CW
//  MAX_HOLD  8   max consecutive grant cycles per owner; 0 = unlimited
//  IDW       localparam = clog2(NREQ), min 1; width of owner index
// PORTS
//  clk     in   1     clock, rising edge
//  reset   in   1     asynchronous, active-high reset
//  req     in   NREQ  request per requester, level, held until done
//  step    in   NREQ  increment strobe per requester
//  clr     in   1     synchronous clear of count
//  gnt     out  NREQ  one-hot grant (all-zero when no owner)
//  owner   out  IDW   index of granted requester; 0 when idle
//  count   out  CW    shared counter value
//  wrap    out  1     1-cycle pulse: count wrapped 2^CW-1 -> 0
//  busy    out  1     1 while in GRANT (== |gnt)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, gnt=0, owner=0, count=0, wrap=0, busy=0.
//   last_owner=NREQ-1, so requester 0 has first priority.
//  All outputs are registered.
//  FSM states: IDLE, GRANT, RELEASE.
//   IDLE: if |req at edge, pick first set req scanning last_owner+1 upward
//    (mod NREQ) -> GRANT. gnt/owner/busy are valid in the next cycle
//    (1-cycle req->gnt latency). No req: stay IDLE.
//   GRANT: hold_cnt starts at 0 and increments each GRANT cycle.
//    Go to RELEASE when req[owner]==0 at an edge, or when MAX_HOLD!=0 and
//    hold_cnt==MAX_HOLD-1. So a grant lasts at most MAX_HOLD cycles.
//   RELEASE: gnt=0, busy=0 for exactly 1 cycle; last_owner<=owner.
//    If |req at edge: arbitrate as in IDLE -> GRANT. Else -> IDLE.
//    A timed-out owner still requesting gets re-granted only after all
//    other requesters in round-robin order.
//  Count update, priority order at each edge:
//   clr=1 -> count<=0, wrap<=0.
//   else if busy and step[owner]=1 -> count<=count+1 mod 2^CW;
//    wrap<=1 iff old count==2^CW-1.
//   else count holds, wrap<=0.
//  Step edge cases:
//   Steps from non-owners are ignored, as are all steps outside GRANT.
//   An owner's step in the same cycle it drops req counts, because gnt is
//    still high.
//   A step in the final timed-out grant cycle counts.
//  clr never affects arbitration state.
//  Exactly one gnt bit is set while busy; owner is consistent with gnt.
// TESTING
//  T1 single owner/wrap: reset, req=0001, 5 step[0] pulses 1 cycle apart
//     -> gnt=0001 from cycle after req; count 1,2,3,0,1; one wrap pulse on 3->0.
//  T2 rotation: req=1111 held, MAX_HOLD=8 -> gnt 0001,0010,0100,1000,0001;
//     each grant 8 cycles, 1 idle cycle (gnt=0000) between grants.
//  T3 non-owner step: gnt=0001, step=0010 for 4 cycles -> count unchanged, wrap=0.
//  T4 clr priority: count=3, step[owner]=1 and clr=1 same cycle -> count=0, wrap=0.
//  T5 early release: owner 1 drops req after 3 grant cycles, req[2]=1
//     -> gnt 0010 for 3 cycles, 0000 for 1 cycle, then 0100.
//  T6 reset mid-grant: gnt=0100, count=2, assert reset -> gnt=0, count=0,
//     owner=0 immediately; after deassert with req=0101 -> gnt=0001 first.

Source files
------------

// File: rtl/step_counter_arbiter.sv
// step_counter_arbiter
//   Shares one modulo-2^CW step counter between NREQ requesters. A round-robin
//   arbiter hands the counter to one requester at a time, and only the owner's
//   step pulses advance the count. Each grant ends on a timeout (MAX_HOLD cycles)
//   or when the owner drops req. Every grant is followed by exactly one cycle
//   with no owner.
//
// Ports
//   clk    in   1     clock, rising edge
//   reset  in   1     asynchronous, active-high reset
//   req    in   NREQ  level request per requester, held until done
//   step   in   NREQ  increment strobe per requester
//   clr    in   1     synchronous clear of count (beats step)
//   gnt    out  NREQ  one-hot grant, all-zero when no owner
//   owner  out  IDW   index of granted requester, 0 when idle
//   count  out  CW    shared counter value
//   wrap   out  1     one-cycle pulse when count wraps 2^CW-1 -> 0
//   busy   out  1     high while a grant is active (== |gnt)
//
// All outputs are registered.

module step_counter_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned CW       = 2,
    parameter int unsigned MAX_HOLD = 8,
    localparam int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] step,
    input  logic            clr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  owner,
    output logic [CW-1:0]   count,
    output logic            wrap,
    output logic            busy
);

    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_RESET = IDW'(NREQ - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic            busy_q, busy_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wrap_q, wrap_d;

    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  cand;
    logic            release_now;

    // Round-robin pick: first set req scanning upward from last_q + 1.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            cand = IDW'((int'(last_q) + i) % int'(NREQ));
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Grant ends when the owner lets go or its time slice is used up.
    assign release_now = !req[owner_q] || ((MAX_HOLD != 0) && (hold_q == HOLD_LAST));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= LAST_RESET;
            hold_q  <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StRelease: state_d = pick_valid ? StGrant : StIdle;
            StGrant:           if (release_now) state_d = StRelease;
            default:           state_d = StIdle;
        endcase
    end

    // Registered-output and datapath next values
    always_comb begin
        gnt_d   = '0;
        owner_d = '0;
        busy_d  = 1'b0;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle, StRelease: begin
                if (pick_valid) begin
                    gnt_d   = NREQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                if (release_now) begin
                    // Remember who just finished so the next scan starts after it.
                    last_d = owner_q;
                end else begin
                    gnt_d   = gnt_q;
                    owner_d = owner_q;
                    busy_d  = 1'b1;
                    hold_d  = hold_q + HW'(1);
                end
            end
            default: ;
        endcase

        // Shared counter: clr wins, then the owner's step while granted.
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (busy_q && step[owner_q]) begin
            count_d = count_q + CW'(1);
            wrap_d  = &count_q;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign wrap  = wrap_q;

endmodule
